lsu_mem_bridge: RTL and testbench

- Parametrised load/store bridge between the datapath memory stage and the DRAM/peripheral bus.
- Generalises the single-stage registered read buffer to a configurable read latency. Adds byte/half/word lane steering, load sign/zero extension, misalignment detection and a stall handshake back to the pipeline.
- Sits between the datapath memory port and the perip_* bus pins of the top level.

---
 rtl/lsu_pkg.sv | 18 +
 rtl/lsu_lane_align.sv | 46 ++++
 rtl/lsu_mem_bridge.sv | 173 +++++++++++++++++
 tb/tb_lsu_mem_bridge.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings for the load/store bridge
// Purpose: size and state encodings plus the read-latency ceiling used by
// lsu_mem_bridge and lsu_lane_align.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int RD_LAT_MAX = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte/half/word write replication and read extract
// Purpose: purely combinational lane steering shared by the load/store bridge
// and the I-cache refill path.
// Ports:
//   size        access size (SZ_BYTE/SZ_HALF/SZ_WORD, anything else = word)
//   unsigned_ld 1 = zero-extend loads, 0 = sign-extend
//   offset      byte offset of the access inside the 32-bit word
//   wdata_in    right-aligned store data
//   rdata_word  raw 32-bit bus word
//   wdata_out   lane-replicated store data
//   rdata_out   extracted and extended load data
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        unsigned_ld,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata_in,
    input  logic [31:0] rdata_word,
    output logic [31:0] wdata_out,
    output logic [31:0] rdata_out
);

    logic [31:0] shifted;

    always_comb begin
        shifted   = rdata_word >> {offset, 3'b000};
        wdata_out = wdata_in;
        rdata_out = shifted;
        case (size)
            SZ_BYTE: begin
                wdata_out = {4{wdata_in[7:0]}};
                rdata_out = {{24{~unsigned_ld & shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                wdata_out = {2{wdata_in[15:0]}};
                rdata_out = {{16{~unsigned_ld & shifted[15]}}, shifted[15:0]};
            end
            default: begin
                wdata_out = wdata_in;
                rdata_out = shifted;
            end
        endcase
    end

endmodule

// File: rtl/lsu_mem_bridge.sv
// rtl/lsu_mem_bridge.sv - load/store bridge from memory stage to perip bus
// Purpose: accepts one load/store at a time, drives the perip_* bus for a
// configurable read latency, steers lanes, extends load data and flags
// misaligned accesses.
// Ports:
//   clk, rst_n                    core clock, async active-low reset
//   req_valid/req_ready           request handshake from the datapath
//   req_wen/req_size/req_unsigned request attributes
//   req_addr/req_wdata            byte address and right-aligned store data
//   stall                         pipeline freeze while busy
//   rsp_valid/rsp_err/rsp_rdata   one-cycle completion
//   perip_*                       word-aligned bus interface
module lsu_mem_bridge
    import lsu_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int RD_LAT       = 1,
    parameter bit MISALIGN_CHK = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [31:0]       rsp_rdata,
    output logic [ADDR_W-1:0] perip_addr,
    output logic              perip_wen,
    output logic [1:0]        perip_mask,
    output logic [31:0]       perip_wdata,
    input  logic [31:0]       perip_rdata
);

    if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
        $error("lsu_mem_bridge: RD_LAT must be in 1..7");
    end

    localparam logic [2:0] CNT_LOAD = 3'(RD_LAT - 1);

    lsu_state_t        state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic              wen_q, wen_d;
    logic              err_q, err_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       data_q, data_d;

    logic [1:0]        req_size_n;
    logic              misaligned;
    logic [1:0]        lane_off;
    logic [31:0]       steered_wdata;
    logic [31:0]       extracted_rdata;

    // Illegal size 2'b11 behaves as a word everywhere downstream.
    assign req_size_n = (req_size == 2'b11) ? SZ_WORD : req_size;
    assign misaligned = MISALIGN_CHK &&
                        (((req_size_n == SZ_HALF) && req_addr[0]) ||
                         ((req_size_n == SZ_WORD) && (req_addr[1:0] != 2'b00)));

    // Half accesses only ever use lane 0 or 2, words always lane 0; this also
    // gives the defined behaviour when misalignment checking is disabled.
    always_comb begin
        case (size_q)
            SZ_BYTE: lane_off = addr_q[1:0];
            SZ_HALF: lane_off = {addr_q[1], 1'b0};
            default: lane_off = 2'b00;
        endcase
    end

    lsu_lane_align u_lane_align (
        .size        (size_q),
        .unsigned_ld (uns_q),
        .offset      (lane_off),
        .wdata_in    (wdata_q),
        .rdata_word  (data_q),
        .wdata_out   (steered_wdata),
        .rdata_out   (extracted_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            wen_q   <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            wen_q   <= wen_d;
            err_q   <= err_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        size_d      = size_q;
        uns_d       = uns_q;
        wen_d       = wen_q;
        err_d       = err_q;
        wdata_d     = wdata_q;
        data_d      = data_q;
        req_ready   = 1'b0;
        stall       = 1'b0;
        rsp_valid   = 1'b0;
        rsp_err     = 1'b0;
        rsp_rdata   = '0;
        perip_addr  = '0;
        perip_wen   = 1'b0;
        perip_mask  = 2'b00;
        perip_wdata = '0;

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                stall     = req_valid & rst_n;
                if (req_valid) begin
                    addr_d  = req_addr;
                    size_d  = req_size_n;
                    uns_d   = req_unsigned;
                    wen_d   = req_wen;
                    wdata_d = req_wdata;
                    err_d   = misaligned;
                    cnt_d   = req_wen ? 3'd0 : CNT_LOAD;
                    state_d = misaligned ? ST_RESP : ST_BUS;
                end
            end
            ST_BUS: begin
                stall       = rst_n;
                perip_addr  = {addr_q[ADDR_W-1:2], 2'b00};
                perip_mask  = size_q;
                perip_wdata = steered_wdata;
                // Stores always run with cnt=0, so their single BUS cycle is the first.
                perip_wen   = wen_q;
                if (cnt_q == 3'd0) begin
                    data_d  = perip_rdata;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                rsp_err   = err_q;
                if (!err_q && !wen_q) begin
                    rsp_rdata = extracted_rdata;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_lsu_mem_bridge.sv
// tb/tb_lsu_mem_bridge.sv - self-checking bench for lsu_mem_bridge
module tb_lsu_mem_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req_valid;
    logic        req_wen;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] bus_word;

    logic [7:1]  req_ready_v;
    logic [7:1]  stall_v;
    logic [7:1]  rsp_valid_v;
    logic [7:1]  rsp_err_v;
    logic [7:1]  perip_wen_v;
    logic [31:0] rsp_rdata_a   [1:7];
    logic [31:0] perip_addr_a  [1:7];
    logic [1:0]  perip_mask_a  [1:7];
    logic [31:0] perip_wdata_a [1:7];

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          lat;
        logic        err;
        logic [31:0] rd;
    } exp_t;
    exp_t sbq[$];

    // One bridge per legal read latency; each has its own bus model that
    // only presents bus_word in the RD_LAT-th BUS cycle.
    for (genvar L = 1; L <= 7; L++) begin : g_dut
        logic [31:0] prd;
        int          bcnt;
        lsu_mem_bridge #(.ADDR_W(32), .RD_LAT(L), .MISALIGN_CHK(1'b1)) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .req_valid    (req_valid),
            .req_ready    (req_ready_v[L]),
            .req_wen      (req_wen),
            .req_size     (req_size),
            .req_unsigned (req_unsigned),
            .req_addr     (req_addr),
            .req_wdata    (req_wdata),
            .stall        (stall_v[L]),
            .rsp_valid    (rsp_valid_v[L]),
            .rsp_err      (rsp_err_v[L]),
            .rsp_rdata    (rsp_rdata_a[L]),
            .perip_addr   (perip_addr_a[L]),
            .perip_wen    (perip_wen_v[L]),
            .perip_mask   (perip_mask_a[L]),
            .perip_wdata  (perip_wdata_a[L]),
            .perip_rdata  (prd)
        );
        initial begin
            prd  = 32'hBAD0_BAD0;
            bcnt = 0;
        end
        always @(negedge clk) begin
            if (stall_v[L] && !req_ready_v[L]) begin
                bcnt = bcnt + 1;
                prd  = (bcnt == L) ? bus_word : 32'hBAD0_BAD0;
            end else begin
                bcnt = 0;
                prd  = 32'hBAD0_BAD0;
            end
        end
    end

    // Drives one request into the RD_LAT=3 bridge and records what it saw.
    task automatic issue(input logic wen, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output int lat, output logic err, output logic [31:0] rd,
                         output int stall_cnt, output int bus_cyc, output int wen_cyc,
                         output logic [1:0] pmask, output logic [31:0] paddr,
                         output logic [31:0] pwdata);
        @(negedge clk);
        req_wen = wen; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        #1;
        stall_cnt = stall_v[3] ? 1 : 0;
        lat = -1; err = 1'bx; rd = 'x;
        bus_cyc = 0; wen_cyc = 0; pmask = 2'b00; paddr = '0; pwdata = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk); #1;
            if (rsp_valid_v[3]) begin
                lat = k; err = rsp_err_v[3]; rd = rsp_rdata_a[3];
                break;
            end
            if (stall_v[3]) stall_cnt++;
            if (stall_v[3] && !req_ready_v[3]) begin
                bus_cyc++;
                paddr = perip_addr_a[3];
                pmask = perip_mask_a[3];
            end
            if (perip_wen_v[3]) begin
                wen_cyc++;
                pwdata = perip_wdata_a[3];
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        int saw;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (req_ready_v[3] !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready_v[3]); end
        checks++; if (stall_v[3] !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall_v[3]); end
        checks++; if (rsp_valid_v[3] !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid_v[3]); end
        checks++; if (perip_wen_v[3] !== 1'b0 || perip_addr_a[3] !== 32'h0 || rsp_rdata_a[3] !== 32'h0)
            begin errors++; $display("FAIL reset_outputs got wen=%b addr=%h rdata=%h want 0", perip_wen_v[3], perip_addr_a[3], rsp_rdata_a[3]); end
        @(negedge clk); rst_n = 1'b1;
        // abort a store mid-BUS
        @(negedge clk);
        req_wen = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h8000_0010; req_wdata = 32'h1122_3344; req_valid = 1'b1;
        saw = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); #1;
            if (perip_wen_v[3]) begin saw = 1; break; end
        end
        checks++; if (saw != 1) begin errors++; $display("FAIL abort_store_wen_seen got %0d want 1", saw); end
        rst_n = 1'b0;
        #1;
        checks++; if (perip_wen_v[3] !== 1'b0) begin errors++; $display("FAIL abort_wen_drop got %b want 0", perip_wen_v[3]); end
        checks++; if (req_ready_v[3] !== 1'b1) begin errors++; $display("FAIL abort_req_ready got %b want 1", req_ready_v[3]); end
        req_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        saw = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); #1;
            if (rsp_valid_v[3]) saw++;
        end
        checks++; if (saw != 0) begin errors++; $display("FAIL abort_no_rsp got %0d pulses want 0", saw); end
        checks++; if (req_ready_v[3] !== 1'b1) begin errors++; $display("FAIL abort_idle_ready got %b want 1", req_ready_v[3]); end
    endtask

    task automatic test_load_word();
        int lat, sc, bc, wc; logic err; logic [31:0] rd, pa, pw; logic [1:0] pm; exp_t e;
        bus_word = 32'hDEAD_BEEF;
        sbq.push_back('{4, 1'b0, 32'hDEAD_BEEF});
        issue(1'b0, 2'b10, 1'b0, 32'h8000_0100, 32'h0, lat, err, rd, sc, bc, wc, pm, pa, pw);
        e = sbq.pop_front();
        checks++; if (lat !== e.lat) begin errors++; $display("FAIL load_word_lat got %0d want %0d", lat, e.lat); end
        checks++; if (rd !== e.rd || err !== e.err) begin errors++; $display("FAIL load_word_data got %h err %b want %h err %b", rd, err, e.rd, e.err); end
        checks++; if (sc != 4) begin errors++; $display("FAIL load_word_stall got %0d want 4", sc); end
        checks++; if (pa !== 32'h8000_0100 || wc != 0) begin errors++; $display("FAIL load_word_bus got addr %h wen %0d want 80000100 0", pa, wc); end
    endtask

    task automatic test_load_ext();
        logic [1:0]  szs [5] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b01};
        logic        unss[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [1:0]  offs[5] = '{2'd2, 2'd3, 2'd1, 2'd2, 2'd0};
        logic [31:0] exps[5] = '{32'hFFFF_FFFF, 32'h0000_0080, 32'h0000_007F, 32'hFFFF_80FF, 32'h0000_7F01};
        int lat, sc, bc, wc; logic err; logic [31:0] rd, pa, pw; logic [1:0] pm; exp_t e;
        bus_word = 32'h80FF_7F01;
        for (int i = 0; i < 5; i++) begin
            sbq.push_back('{4, 1'b0, exps[i]});
            issue(1'b0, szs[i], unss[i], 32'h8000_0300 | {30'h0, offs[i]}, 32'h0,
                  lat, err, rd, sc, bc, wc, pm, pa, pw);
            e = sbq.pop_front();
            checks++;
            if (rd !== e.rd || lat !== e.lat || err !== e.err) begin
                errors++;
                $display("FAIL load_ext_%0d got %h lat %0d err %b want %h lat %0d err %b", i, rd, lat, err, e.rd, e.lat, e.err);
            end
        end
    endtask

    task automatic test_store();
        int lat, sc, bc, wc; logic err; logic [31:0] rd, pa, pw; logic [1:0] pm; exp_t e;
        sbq.push_back('{2, 1'b0, 32'h0});
        issue(1'b1, 2'b01, 1'b0, 32'h8000_0202, 32'h1234_ABCD, lat, err, rd, sc, bc, wc, pm, pa, pw);
        e = sbq.pop_front();
        checks++; if (lat !== e.lat || rd !== e.rd || err !== e.err) begin errors++; $display("FAIL store_half_rsp got lat %0d rd %h err %b want %0d %h %b", lat, rd, err, e.lat, e.rd, e.err); end
        checks++; if (wc != 1 || bc != 1) begin errors++; $display("FAIL store_half_wen_cycles got wen %0d bus %0d want 1 1", wc, bc); end
        checks++; if (pm !== 2'b01 || pw !== 32'hABCD_ABCD || pa !== 32'h8000_0200)
            begin errors++; $display("FAIL store_half_bus got mask %b data %h addr %h want 01 abcdabcd 80000200", pm, pw, pa); end
        sbq.push_back('{2, 1'b0, 32'h0});
        issue(1'b1, 2'b00, 1'b0, 32'h8000_0207, 32'h0000_00A5, lat, err, rd, sc, bc, wc, pm, pa, pw);
        e = sbq.pop_front();
        checks++; if (lat !== e.lat || pw !== 32'hA5A5_A5A5 || pa !== 32'h8000_0204 || pm !== 2'b00)
            begin errors++; $display("FAIL store_byte got lat %0d data %h addr %h mask %b want %0d a5a5a5a5 80000204 00", lat, pw, pa, pm, e.lat); end
    endtask

    task automatic test_misalign();
        int lat, sc, bc, wc; logic err; logic [31:0] rd, pa, pw; logic [1:0] pm; exp_t e;
        bus_word = 32'h5555_5555;
        sbq.push_back('{1, 1'b1, 32'h0});
        issue(1'b0, 2'b10, 1'b0, 32'h8000_0001, 32'h0, lat, err, rd, sc, bc, wc, pm, pa, pw);
        e = sbq.pop_front();
        checks++; if (lat !== e.lat || err !== e.err || rd !== e.rd) begin errors++; $display("FAIL misalign_word got lat %0d err %b rd %h want %0d %b %h", lat, err, rd, e.lat, e.err, e.rd); end
        checks++; if (bc != 0 || wc != 0) begin errors++; $display("FAIL misalign_no_bus got bus %0d wen %0d want 0 0", bc, wc); end
        sbq.push_back('{1, 1'b1, 32'h0});
        issue(1'b1, 2'b01, 1'b0, 32'h8000_0003, 32'hFFFF_FFFF, lat, err, rd, sc, bc, wc, pm, pa, pw);
        e = sbq.pop_front();
        checks++; if (lat !== e.lat || err !== e.err || wc != 0) begin errors++; $display("FAIL misalign_half_store got lat %0d err %b wen %0d want %0d %b 0", lat, err, wc, e.lat, e.err); end
    endtask

    task automatic test_back_to_back();
        int due_q[1:7][$];
        int last_rsp[1:7];
        int nrsp[1:7];
        int d;
        rst_n = 1'b0;
        req_valid = 1'b0;
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        bus_word = 32'hCAFE_0001;
        for (int L = 1; L <= 7; L++) begin last_rsp[L] = -1; nrsp[L] = 0; end
        for (int cyc = 0; cyc < 80; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                req_wen = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
                req_addr = 32'h8000_0400; req_wdata = 32'h0; req_valid = 1'b1;
            end
            if (cyc == 60) req_valid = 1'b0;
            #1;
            for (int L = 1; L <= 7; L++) begin
                if (rsp_valid_v[L]) begin
                    nrsp[L]++;
                    d = -1;
                    if (due_q[L].size() > 0) d = due_q[L].pop_front();
                    checks++;
                    if (d != cyc || rsp_rdata_a[L] !== 32'hCAFE_0001) begin
                        errors++;
                        $display("FAIL sweep_lat%0d_rsp got cycle %0d data %h want cycle %0d data cafe0001", L, cyc, rsp_rdata_a[L], d);
                    end
                    last_rsp[L] = cyc;
                end
                if (req_ready_v[L] && req_valid) begin
                    if (last_rsp[L] >= 0) begin
                        checks++;
                        if (cyc != last_rsp[L] + 1) begin
                            errors++;
                            $display("FAIL sweep_lat%0d_accept got cycle %0d want %0d", L, cyc, last_rsp[L] + 1);
                        end
                    end
                    due_q[L].push_back(cyc + L + 1);
                end
            end
        end
        for (int L = 1; L <= 7; L++) begin
            checks++;
            if (due_q[L].size() != 0 || nrsp[L] < 60 / (L + 2)) begin
                errors++;
                $display("FAIL sweep_lat%0d_count got %0d rsps %0d pending want >=%0d and 0", L, nrsp[L], due_q[L].size(), 60 / (L + 2));
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; bus_word = '0;
        test_reset();
        test_load_word();
        test_load_ext();
        test_store();
        test_misalign();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
